selevy_run_ctrl: RTL and testbench

Parametrised run controller for the selevy core in simulation and FPGA bring-up. It replaces a hand-toggled reset and a fixed clock count with a controller that:
- sequences the core's reset,
- bounds execution by a cycle budget,
- detects halt as a PC stuck at one value,
- compacts all data-memory writes into a signature checked against an expected value.

It sits beside the selevy top, driving core reset and snooping the PC and data-memory write port.

---
 rtl/selevy_run_ctrl_pkg.sv | 16 +
 rtl/selevy_sig_acc.sv | 38 +++
 rtl/selevy_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_selevy_run_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/selevy_run_ctrl_pkg.sv
// Shared types and defaults for the selevy run controller.
package selevy_run_ctrl_pkg;

  // Controller phases: idle in reset, hold core reset, run, finished.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } run_state_e;

  localparam int unsigned DefaultMaxCycles   = 11;
  localparam int unsigned DefaultResetCycles = 1;
  localparam int unsigned DefaultHaltRepeat  = 3;

endpackage

// File: rtl/selevy_sig_acc.sv
// Rotate-left-by-one XOR accumulator that compacts a stream of (addr, data)
// writes into a single XLEN-bit signature. Clear has priority over enable.
module selevy_sig_acc #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] sig_o
);

  logic [XLEN-1:0] sig_q, sig_d;

  // Next signature: clear, fold in one write, or hold.
  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ addr_i ^ data_i;
    end
  end

  // Signature register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/selevy_run_ctrl.sv
// Run controller for the selevy core: sequences core reset, bounds the run by a
// cycle budget, detects halt as a PC that stops changing, and signs all
// data-memory writes for a pass/fail verdict.
module selevy_run_ctrl
  import selevy_run_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     RESET_CYCLES = DefaultResetCycles,
  parameter int unsigned     MAX_CYCLES   = DefaultMaxCycles,
  parameter int unsigned     HALT_REPEAT  = DefaultHaltRepeat,
  parameter logic [XLEN-1:0] SIG_EXPECTED = '0,
  localparam int unsigned    CW           = $clog2(MAX_CYCLES + 1)
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  output logic            core_reset,
  input  logic [XLEN-1:0] pc,
  input  logic            dmem_we,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  output logic            running,
  output logic            done,
  output logic            halted,
  output logic            timeout,
  output logic            pass,
  output logic [CW-1:0]   cycle_count,
  output logic [XLEN-1:0] signature
);

  localparam int unsigned HoldW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned RepW  = $clog2(HALT_REPEAT + 1);

  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0]    CntMax   = CW'(MAX_CYCLES);
  localparam logic [RepW-1:0]  RepMax   = RepW'(HALT_REPEAT);

  run_state_e      state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RepW-1:0]  rep_q, rep_d;
  logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
  logic             prev_vld_q, prev_vld_d;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;
  logic             core_reset_q, running_q, done_q;
  logic             sig_clr, sig_en;

  // Next-state, counters and halt detector.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    prev_pc_d  = prev_pc_q;
    prev_vld_d = prev_vld_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    sig_clr    = 1'b0;
    sig_en     = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StHold;
          hold_d     = '0;
          cnt_d      = '0;
          rep_d      = '0;
          prev_vld_d = 1'b0;
          halted_d   = 1'b0;
          timeout_d  = 1'b0;
          sig_clr    = 1'b1;
        end
      end

      StHold: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      StRun: begin
        sig_en = dmem_we;

        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end

        // The first run cycle has no valid previous PC, so it never counts.
        if (prev_vld_q && (pc == prev_pc_q)) begin
          if (rep_q != RepMax) begin
            rep_d = rep_q + 1'b1;
          end
        end else begin
          rep_d = '0;
        end
        prev_pc_d  = pc;
        prev_vld_d = 1'b1;

        // Halt wins over timeout when both complete on the same cycle.
        if (rep_d == RepMax) begin
          halted_d = 1'b1;
          state_d  = StDone;
        end else if (cnt_d == CntMax) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      cnt_q        <= '0;
      rep_q        <= '0;
      prev_pc_q    <= '0;
      prev_vld_q   <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      rep_q        <= rep_d;
      prev_pc_q    <= prev_pc_d;
      prev_vld_q   <= prev_vld_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      core_reset_q <= (state_d != StRun);
      running_q    <= (state_d == StRun);
      done_q       <= (state_d == StDone);
    end
  end

  selevy_sig_acc #(
    .XLEN (XLEN)
  ) u_sig_acc (
    .clk_i  (CLK),
    .rst_i  (reset),
    .clr_i  (sig_clr),
    .en_i   (sig_en),
    .addr_i (dmem_addr),
    .data_i (dmem_wdata),
    .sig_o  (signature)
  );

  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;
  assign pass        = done_q & (signature == SIG_EXPECTED);

endmodule

// File: tb/tb_selevy_run_ctrl.sv
// Self-checking bench for selevy_run_ctrl: directed and random run traces are
// applied and every finished run is compared against a trace-level model.
module tb_selevy_run_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RC   = 2;
  localparam int unsigned MC   = 11;
  localparam int unsigned HR   = 3;
  localparam logic [31:0] SE   = 32'hD;
  localparam int unsigned CW   = $clog2(MC + 1);
  localparam int          TLEN = 40;

  logic            CLK = 1'b0;
  logic            reset;
  logic            start = 1'b0;
  logic            core_reset;
  logic [XLEN-1:0] pc = '0;
  logic            dmem_we = 1'b0;
  logic [XLEN-1:0] dmem_addr = '0;
  logic [XLEN-1:0] dmem_wdata = '0;
  logic            running, done, halted, timeout, pass;
  logic [CW-1:0]   cycle_count;
  logic [XLEN-1:0] signature;

  // Per-run-cycle stimulus trace.
  logic [31:0] t_pc   [TLEN];
  logic [31:0] t_addr [TLEN];
  logic [31:0] t_data [TLEN];
  bit          t_we   [TLEN];
  bit          t_st   [TLEN];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  selevy_run_ctrl #(
    .XLEN         (XLEN),
    .RESET_CYCLES (RC),
    .MAX_CYCLES   (MC),
    .HALT_REPEAT  (HR),
    .SIG_EXPECTED (SE)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .core_reset  (core_reset),
    .pc          (pc),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .running     (running),
    .done        (done),
    .halted      (halted),
    .timeout     (timeout),
    .pass        (pass),
    .cycle_count (cycle_count),
    .signature   (signature)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outcome of a run from the trace alone: the run stops at the first cycle
  // where the PC has equalled its predecessor HR times in a row, or else after
  // MC cycles; the signature folds in every write up to and including that one.
  function automatic void model(output int cyc, output int cnt, output logic [31:0] sig,
                                output bit hlt, output bit to);
    int same_run;
    cyc = 0; cnt = 0; sig = '0; hlt = 0; to = 0; same_run = 0;
    for (int i = 0; i < TLEN; i++) begin
      cnt = i + 1;
      if (t_we[i]) sig = {sig[30:0], sig[31]} ^ t_addr[i] ^ t_data[i];
      same_run = (i > 0 && t_pc[i] == t_pc[i-1]) ? same_run + 1 : 0;
      if (same_run == HR) begin hlt = 1; cyc = cnt; return; end
      if (cnt == MC) begin to = 1; cyc = cnt; return; end
    end
  endfunction

  task automatic clear_trace();
    for (int i = 0; i < TLEN; i++) begin
      t_pc[i] = 32'(i * 4); t_addr[i] = '0; t_data[i] = '0; t_we[i] = 0; t_st[i] = 0;
    end
  endtask

  task automatic gen_random();
    int keep;
    keep = $urandom_range(0, 3);
    t_pc[0] = $urandom & 32'hFFFF_FFFC;
    for (int i = 0; i < TLEN; i++) begin
      if (i > 0) t_pc[i] = ($urandom_range(0, 3) < keep) ? t_pc[i-1] : t_pc[i-1] + 32'd4;
      t_we[i]   = $urandom_range(0, 1) == 1;
      t_addr[i] = $urandom;
      t_data[i] = $urandom;
      t_st[i]   = $urandom_range(0, 7) == 0;
    end
  endtask

  // Launch a run from IDLE/DONE, play the trace and check the final result.
  task automatic do_run(input string tag);
    int cyc, cnt, used;
    logic [31:0] sig;
    bit hlt, to;
    model(cyc, cnt, sig, hlt, to);
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    for (int h = 0; h < int'(RC); h++) begin
      chk({tag, ".hold_core_reset"}, core_reset, 1'b1);
      chk({tag, ".hold_running"}, running, 1'b0);
      chk({tag, ".hold_done"}, done, 1'b0);
      start = (h == 0);  // must be ignored while holding
      @(negedge CLK);
    end
    start = 1'b0;
    chk({tag, ".run_entry"}, {core_reset, running}, 2'b01);
    used = 0;
    while (running === 1'b1 && used < TLEN) begin
      pc = t_pc[used]; dmem_we = t_we[used];
      dmem_addr = t_addr[used]; dmem_wdata = t_data[used];
      start = t_st[used];  // must be ignored while running
      @(negedge CLK);
      used++;
    end
    start = 1'b0; dmem_we = 1'b0;
    chk({tag, ".run_cycles"}, used, cyc);
    chk({tag, ".done"}, {done, running, core_reset}, 3'b101);
    chk({tag, ".halted"}, halted, hlt);
    chk({tag, ".timeout"}, timeout, to);
    chk({tag, ".cycle_count"}, cycle_count, cnt);
    chk({tag, ".signature"}, signature, sig);
    chk({tag, ".pass"}, pass, sig == SE);
    // Writes and PC motion while DONE must not disturb the result.
    repeat (2) begin
      pc = $urandom; dmem_we = 1'b1; dmem_addr = $urandom; dmem_wdata = $urandom;
      @(negedge CLK);
    end
    dmem_we = 1'b0;
    chk({tag, ".frozen"}, {done, halted, timeout, cycle_count, signature},
        {1'b1, hlt, to, CW'(cnt), sig});
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reset.outputs", {core_reset, running, done, halted, timeout, pass},
        6'b100000);
    chk("reset.counters", {cycle_count, signature}, '0);
    reset = 1'b0;
    @(negedge CLK);
    chk("idle.core_reset", {core_reset, done}, 2'b10);

    // PC strides by 4 without writes: budget expires.
    clear_trace();
    do_run("timeout");
    chk("timeout.const", {timeout, halted, cycle_count, signature}, {2'b10, CW'(11), 32'h0});

    // PC climbs to 0x10 and sticks: halt on the third repeat.
    clear_trace();
    for (int i = 4; i < TLEN; i++) t_pc[i] = 32'h10;
    do_run("halt");
    chk("halt.const", {halted, timeout, cycle_count}, {2'b10, CW'(8)});

    // Two writes producing the expected signature.
    clear_trace();
    t_we[0] = 1; t_addr[0] = 32'h0; t_data[0] = 32'h5;
    t_we[1] = 1; t_addr[1] = 32'h4; t_data[1] = 32'h3;
    do_run("sig");
    chk("sig.const", {signature, pass}, {32'hD, 1'b1});

    // Halt completes on the final budget cycle: halt takes priority.
    clear_trace();
    for (int i = 7; i < TLEN; i++) t_pc[i] = 32'h1C;
    t_we[10] = 1; t_addr[10] = 32'hA0; t_data[10] = 32'h0F;
    do_run("tie");
    chk("tie.const", {halted, timeout, cycle_count}, {2'b10, CW'(11)});

    // Random traces.
    for (int r = 0; r < 24; r++) begin
      gen_random();
      do_run($sformatf("rand%0d", r));
    end

    // Reset mid-run, then a restart must reproduce the full run.
    gen_random();
    t_we[0] = 1; t_addr[0] = 32'h1234_5678;
    do_run("abort_ref");
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (RC) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      pc = t_pc[i]; dmem_we = t_we[i]; dmem_addr = t_addr[i]; dmem_wdata = t_data[i];
      @(negedge CLK);
    end
    dmem_we = 1'b0;
    chk("abort.mid_run", running, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("abort.outputs", {core_reset, running, done, halted, timeout, pass}, 6'b100000);
    chk("abort.counters", {cycle_count, signature}, '0);
    @(negedge CLK); reset = 1'b0;
    do_run("abort_rerun");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
